lsu_mem_ctrl: RTL

- Load/store unit sitting downstream of the ALU in the RV32I datapath.
- Takes the effective address computed by the ALU (rs1 + imm) for I_LOAD_TYPE and S_TYPE instructions and runs a request/grant/response handshake with data memory.
- Generates byte enables and write-data lane replication; extracts and sign/zero-extends load data.
- Drives a stall to the control unit until the access completes, errors, or times out.

---
 rtl/lsu_mem_ctrl_pkg.sv | 47 ++++
 rtl/lsu_data_align.sv | 57 +++++
 rtl/lsu_mem_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// rtl/lsu_mem_ctrl_pkg.sv - shared types, encodings and legality helper for the load/store unit
package lsu_mem_ctrl_pkg;

    typedef logic [6:0]  RV32I_OPCODE_t;
    typedef logic [31:0] RV32I_OPERAND_t;
    typedef logic [2:0]  RV32I_FUNCT3_t;
    typedef logic [3:0]  LSU_BE_t;

    localparam RV32I_OPCODE_t I_LOAD_TYPE = 7'b0000011;
    localparam RV32I_OPCODE_t S_TYPE      = 7'b0100011;

    localparam RV32I_FUNCT3_t F3_LB  = 3'b000;
    localparam RV32I_FUNCT3_t F3_LH  = 3'b001;
    localparam RV32I_FUNCT3_t F3_LW  = 3'b010;
    localparam RV32I_FUNCT3_t F3_LBU = 3'b100;
    localparam RV32I_FUNCT3_t F3_LHU = 3'b101;
    localparam RV32I_FUNCT3_t F3_SB  = 3'b000;
    localparam RV32I_FUNCT3_t F3_SH  = 3'b001;
    localparam RV32I_FUNCT3_t F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT_RSP,
        LSU_RESP,
        LSU_ERR
    } lsu_state_t;

    // Store encodings share values with LB/LH/LW, so one case covers both;
    // the unsigned loads are the only codes that depend on direction.
    function automatic logic lsu_access_legal(input logic is_store,
                                              input RV32I_FUNCT3_t f3,
                                              input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_LB:   ok = 1'b1;
            F3_LH:   ok = ~addr_lo[0];
            F3_LW:   ok = (addr_lo == 2'b00);
            F3_LBU:  ok = ~is_store;
            F3_LHU:  ok = ~is_store & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - byte enables, store lane replication and load extraction/extension
import lsu_mem_ctrl_pkg::*;

module lsu_data_align (
    input  RV32I_FUNCT3_t  req_funct3,
    input  logic [1:0]     req_addr_lo,
    input  RV32I_OPERAND_t store_data,
    output LSU_BE_t        be,
    output RV32I_OPERAND_t wdata,
    input  RV32I_FUNCT3_t  rsp_funct3,
    input  logic [1:0]     rsp_addr_lo,
    input  RV32I_OPERAND_t rdata,
    output RV32I_OPERAND_t load_data
);

    RV32I_FUNCT3_t  req_size;
    RV32I_OPERAND_t lane;

    // Access size ignores the signedness bit so loads and stores share one decode
    always_comb begin
        req_size = {1'b0, req_funct3[1:0]};
        be       = 4'b0000;
        wdata    = store_data;
        case (req_size)
            F3_SB: begin
                be    = 4'b0001 << req_addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            F3_SH: begin
                be    = 4'b0011 << req_addr_lo;
                wdata = {2{store_data[15:0]}};
            end
            F3_SW: begin
                be    = 4'b1111;
                wdata = store_data;
            end
            default: begin
                be    = 4'b0000;
                wdata = store_data;
            end
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend by access type
    always_comb begin
        lane      = rdata >> {rsp_addr_lo, 3'b000};
        load_data = lane;
        case (rsp_funct3)
            F3_LB:   load_data = {{24{lane[7]}}, lane[7:0]};
            F3_LBU:  load_data = {24'h0, lane[7:0]};
            F3_LH:   load_data = {{16{lane[15]}}, lane[15:0]};
            F3_LHU:  load_data = {16'h0, lane[15:0]};
            default: load_data = lane;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit request/grant/response controller with timeout
import lsu_mem_ctrl_pkg::*;

module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int          ADDR_W         = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  RV32I_OPCODE_t       opcode,
    input  logic [2:0]          funct3,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [31:0]         store_data,
    output logic                stall,
    output logic                done,
    output logic [31:0]         load_data,
    output logic                misaligned,
    output logic                bus_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [3:0]          mem_be,
    output logic [31:0]         mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [31:0]         mem_rdata
);

    lsu_state_t     state;
    RV32I_FUNCT3_t  f3_q;
    logic [1:0]     lo_q;
    logic [31:0]    to_cnt;
    LSU_BE_t        be_n;
    RV32I_OPERAND_t wdata_n;
    RV32I_OPERAND_t ld_ext;
    logic           is_ls;
    logic           is_store;
    logic           legal;
    logic           timeout_hit;

    // Request-side lanes come from live inputs, response side from latched access info
    lsu_data_align u_align (
        .req_funct3  (funct3),
        .req_addr_lo (addr[1:0]),
        .store_data  (store_data),
        .be          (be_n),
        .wdata       (wdata_n),
        .rsp_funct3  (f3_q),
        .rsp_addr_lo (lo_q),
        .rdata       (mem_rdata),
        .load_data   (ld_ext)
    );

    // Decode the incoming request and the timeout condition
    always_comb begin
        is_store    = (opcode == S_TYPE);
        is_ls       = (opcode == I_LOAD_TYPE) || is_store;
        legal       = lsu_access_legal(is_store, funct3, addr[1:0]);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TIMEOUT_CYCLES - 1);
    end

    // Access FSM; all outputs registered, pulses cleared by default every cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= LSU_IDLE;
            f3_q       <= '0;
            lo_q       <= '0;
            to_cnt     <= '0;
            stall      <= 1'b0;
            done       <= 1'b0;
            load_data  <= '0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (start && is_ls) begin
                        f3_q      <= funct3;
                        lo_q      <= addr[1:0];
                        mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        mem_be    <= be_n;
                        mem_wdata <= wdata_n;
                        mem_we    <= is_store;
                        stall     <= 1'b1;
                        if (legal) begin
                            state   <= LSU_REQ;
                            mem_req <= 1'b1;
                            to_cnt  <= '0;
                        end else begin
                            state      <= LSU_ERR;
                            misaligned <= 1'b1;
                        end
                    end
                end
                LSU_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        to_cnt  <= '0;
                        if (mem_we) begin
                            state <= LSU_RESP;
                            done  <= 1'b1;
                        end else begin
                            state <= LSU_WAIT_RSP;
                        end
                    end else if (timeout_hit) begin
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        stall   <= 1'b0;
                        state   <= LSU_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                LSU_WAIT_RSP: begin
                    if (mem_rvalid) begin
                        load_data <= ld_ext;
                        done      <= 1'b1;
                        state     <= LSU_RESP;
                    end else if (timeout_hit) begin
                        bus_err <= 1'b1;
                        stall   <= 1'b0;
                        state   <= LSU_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                LSU_RESP, LSU_ERR: begin
                    stall <= 1'b0;
                    state <= LSU_IDLE;
                end
                default: begin
                    stall   <= 1'b0;
                    mem_req <= 1'b0;
                    state   <= LSU_IDLE;
                end
            endcase
        end
    end

endmodule
